frame_sequencer: RTL
====================

# frame_sequencer

Host-side frame controller that sits between the AXI write port and the accelerator top. It enforces the load order: weights first, then whole input frames. It counts weight and input words, gates out-of-order writes, watches the accelerator's result-valid flag with a watchdog, and raises a one-cycle completion interrupt per frame. State, frame count and sticky error flags are exported for the host status registers.

## Interface
- AXI_ADDR_WIDTH, 20: host byte-address width.
- OFFSET_OUTPUT, 'h6_0000: first byte past the input region; input region is addr < OFFSET_OUTPUT.
- OFFSET_RESET, 'h6_0810: soft-reset register address.
- OFFSET_WEIGHT, 'h6_0818: first weight byte address.
- WEIGHT_BYTES, 152646: size of the weight region in bytes.
- WEIGHT_WORDS, 19081: 64-bit weight writes per full load.
- INPUT_WORDS, 49152: 64-bit input writes per frame.
- TIMEOUT_CYCLES, 2**24: maximum number of WAIT cycles before a timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_wr_en  in  1  host write strobe.
- axi_wr_addr  in  AXI_ADDR_WIDTH  host write byte address.
- axi_wr_data  in  64  host write data; only bit 0 is used, for soft reset.
- axi_wr_strobe  in  8  byte enables; a write counts only if |axi_wr_strobe.
- acc_o_valid  in  1  accelerator result-valid level.
- fwd_wr_en  out  1  gated write enable to the accelerator write port.
- state  out  3  current FSM state encoding.
- weights_loaded  out  1  high once a full weight load has completed.
- frame_cnt  out  32  number of completed frames.
- irq_done  out  1  one-cycle pulse when a frame completes.
- err_order  out  1  sticky flag: an out-of-order write was dropped.
- err_timeout  out  1  sticky flag: the watchdog expired.

## Operation
- Write classes, decoded when axi_wr_en && |axi_wr_strobe:
  - W (weight): OFFSET_WEIGHT <= addr < OFFSET_WEIGHT+WEIGHT_BYTES.
  - I (input): addr < OFFSET_OUTPUT.
  - R (soft reset): addr == OFFSET_RESET && axi_wr_strobe[0] && axi_wr_data[0].
  - O (other): anything else.
- States:
  - IDLE=0:
    - W → LOAD_W, count 1.
    - I is dropped.
  - LOAD_W=1:
    - W increments wcnt.
    - The write that makes wcnt == WEIGHT_WORDS → READY, and weights_loaded sets.
    - I is dropped.
  - READY=2:
    - I → STREAM, icnt=1.
    - W is dropped.
  - STREAM=3:
    - I increments icnt.
    - The write that makes icnt == INPUT_WORDS → WAIT, and the watchdog clears to 0.
    - W is dropped.
  - WAIT=4:
    - A rising edge of acc_o_valid → READY, frame_cnt+1, irq_done pulses.
    - The watchdog counts every cycle; reaching TIMEOUT_CYCLES-1 → ERR, err_timeout sets.
    - W and I are dropped.
  - ERR=5:
    - W and I are dropped.
    - The only exit is R or rst_n.
- Rising-edge detection uses a registered copy of acc_o_valid. A level that is already high on entry to WAIT does not count as an edge.
- A dropped write sets err_order. Dropping happens in the same cycle: fwd_wr_en=0.
- fwd_wr_en = axi_wr_en && (write allowed in current state); combinational.
  - O and R writes are always forwarded.
- R in any state has the same effect as reset, except that it is synchronous: the next state is IDLE and every counter and flag clears.
  - When R and another event occur in the same cycle, R wins.
- Counter widths:
  - wcnt: $clog2(WEIGHT_WORDS+1).
  - icnt: $clog2(INPUT_WORDS+1).
  - watchdog: $clog2(TIMEOUT_CYCLES).
  - frame_cnt: 32 bits, wraps from 2^32-1 to 0.

## Timing
- Reset values, all outputs:
  - state=IDLE; fwd_wr_en follows its inputs.
  - weights_loaded, irq_done, err_order, err_timeout = 0; frame_cnt = 0.
  - Internal counters and the acc_o_valid delay register = 0.
- state, counters and flags update on the clk edge that samples the qualifying write or edge. There is no throughput limit: a write is accepted every cycle.
- irq_done is registered: it is high for exactly the one cycle in which state first reads READY after WAIT.
- A weight or input write that lands in the same cycle as a state transition is judged against the pre-transition state.
- rst_n asserted mid-frame clears everything immediately, asynchronously.

## Test plan
Bench uses WEIGHT_WORDS=3, INPUT_WORDS=4, TIMEOUT_CYCLES=16.
- Normal frame:
  - Stimulus: 3 W writes, 4 I writes, then acc_o_valid rises 5 cycles later.
  - Required: state goes 0→1→2→3→4→2; weights_loaded=1; frame_cnt=1; one irq_done pulse; fwd_wr_en high for all 7 writes.
- Order violation:
  - Stimulus: I write in IDLE, then W write in READY.
  - Required: fwd_wr_en=0 on both; err_order=1; state unchanged.
- Timeout:
  - Stimulus: reach WAIT with acc_o_valid held low.
  - Required: after 16 cycles state=ERR and err_timeout=1; further I writes are dropped.
- Soft reset and strobe qualification:
  - Stimulus: a write to 'h6_0810 with data=1, strobe='h01 while in STREAM.
  - Required: the next cycle has state=IDLE, all counters 0, weights_loaded=0.
  - Also: the same write with strobe='h00 has no effect.
- Stale valid level:
  - Stimulus: acc_o_valid already high on entry to WAIT.
  - Required: no completion until it falls and rises again; then irq_done and frame_cnt+1.
- Async reset and counter wrap:
  - Stimulus: rst_n low during LOAD_W after 2 W writes.
  - Required: all outputs take their reset values without waiting for a clock edge.
  - Stimulus: force frame_cnt to 'hFFFF_FFFF and complete a frame.
  - Required: frame_cnt=0.

Source files
------------

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : Host-side load-order controller. Admits weights first, then
//               whole input frames, and watches the accelerator with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int OFFSET_OUTPUT  = 'h6_0000,
    parameter int OFFSET_RESET   = 'h6_0810,
    parameter int OFFSET_WEIGHT  = 'h6_0818,
    parameter int WEIGHT_BYTES   = 152646,
    parameter int WEIGHT_WORDS   = 19081,
    parameter int INPUT_WORDS    = 49152,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
    input  logic [63:0]               axi_wr_data,
    input  logic [7:0]                axi_wr_strobe,
    input  logic                      acc_o_valid,
    output logic                      fwd_wr_en,
    output logic [2:0]                state,
    output logic                      weights_loaded,
    output logic [31:0]               frame_cnt,
    output logic                      irq_done,
    output logic                      err_order,
    output logic                      err_timeout
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load_w = 3'd1;
    localparam logic [2:0] c_st_ready  = 3'd2;
    localparam logic [2:0] c_st_stream = 3'd3;
    localparam logic [2:0] c_st_wait   = 3'd4;
    localparam logic [2:0] c_st_err    = 3'd5;

    localparam int c_wcnt_w = $clog2(WEIGHT_WORDS + 1);
    localparam int c_icnt_w = $clog2(INPUT_WORDS + 1);
    localparam int c_wd_w   = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_wcnt_w-1:0] c_wcnt_full = c_wcnt_w'(WEIGHT_WORDS);
    localparam logic [c_icnt_w-1:0] c_icnt_full = c_icnt_w'(INPUT_WORDS);
    localparam logic [c_wd_w-1:0]   c_wd_last   = c_wd_w'(TIMEOUT_CYCLES - 1);

    localparam logic [31:0] c_w_lo  = 32'(OFFSET_WEIGHT);
    localparam logic [31:0] c_w_hi  = 32'(OFFSET_WEIGHT + WEIGHT_BYTES);
    localparam logic [31:0] c_i_hi  = 32'(OFFSET_OUTPUT);
    localparam logic [31:0] c_r_adr = 32'(OFFSET_RESET);

    logic [2:0]          r_state;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic [c_icnt_w-1:0] r_icnt;
    logic [c_wd_w-1:0]   r_wdog;
    logic [31:0]         r_frame_cnt;
    logic                r_weights_loaded;
    logic                r_irq_done;
    logic                r_err_order;
    logic                r_err_timeout;
    logic                r_acc_valid_d;

    logic [31:0]         w_addr_ext;
    logic                w_qual;
    logic                w_is_w;
    logic                w_is_i;
    logic                w_is_r;
    logic                w_allow_w;
    logic                w_allow_i;
    logic                w_drop;
    logic                w_acc_rise;
    logic [c_wcnt_w-1:0] w_wcnt_nxt;
    logic [c_icnt_w-1:0] w_icnt_nxt;
    logic                w_unused;

    // Write classification; the weight and input windows never overlap the reset register.
    assign w_addr_ext = 32'(axi_wr_addr);
    assign w_qual     = axi_wr_en && (|axi_wr_strobe);
    assign w_is_w     = w_qual && (w_addr_ext >= c_w_lo) && (w_addr_ext < c_w_hi);
    assign w_is_i     = w_qual && (w_addr_ext < c_i_hi);
    assign w_is_r     = w_qual && (w_addr_ext == c_r_adr) && axi_wr_strobe[0] && axi_wr_data[0];

    assign w_allow_w  = (r_state == c_st_idle)  || (r_state == c_st_load_w);
    assign w_allow_i  = (r_state == c_st_ready) || (r_state == c_st_stream);
    assign w_drop     = (w_is_w && !w_allow_w) || (w_is_i && !w_allow_i);

    assign fwd_wr_en  = axi_wr_en && !w_drop;

    // A level already high when WAIT is entered is masked by the delayed copy.
    assign w_acc_rise = acc_o_valid && !r_acc_valid_d;

    assign w_wcnt_nxt = (r_state == c_st_idle)  ? c_wcnt_w'(1) : r_wcnt + 1'b1;
    assign w_icnt_nxt = (r_state == c_st_ready) ? c_icnt_w'(1) : r_icnt + 1'b1;

    assign w_unused   = ^axi_wr_data[63:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_idle;
            r_wcnt           <= '0;
            r_icnt           <= '0;
            r_wdog           <= '0;
            r_frame_cnt      <= '0;
            r_weights_loaded <= 1'b0;
            r_irq_done       <= 1'b0;
            r_err_order      <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_acc_valid_d    <= 1'b0;
        end else if (w_is_r) begin
            r_state          <= c_st_idle;
            r_wcnt           <= '0;
            r_icnt           <= '0;
            r_wdog           <= '0;
            r_frame_cnt      <= '0;
            r_weights_loaded <= 1'b0;
            r_irq_done       <= 1'b0;
            r_err_order      <= 1'b0;
            r_err_timeout    <= 1'b0;
            r_acc_valid_d    <= 1'b0;
        end else begin
            r_acc_valid_d <= acc_o_valid;
            r_irq_done    <= 1'b0;
            if (w_drop) begin
                r_err_order <= 1'b1;
            end
            case (r_state)
                c_st_idle, c_st_load_w: begin
                    if (w_is_w) begin
                        r_wcnt <= w_wcnt_nxt;
                        if (w_wcnt_nxt == c_wcnt_full) begin
                            r_state          <= c_st_ready;
                            r_weights_loaded <= 1'b1;
                        end else begin
                            r_state <= c_st_load_w;
                        end
                    end
                end
                c_st_ready, c_st_stream: begin
                    if (w_is_i) begin
                        r_icnt <= w_icnt_nxt;
                        if (w_icnt_nxt == c_icnt_full) begin
                            r_state <= c_st_wait;
                            r_wdog  <= '0;
                        end else begin
                            r_state <= c_st_stream;
                        end
                    end
                end
                c_st_wait: begin
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (w_acc_rise) begin
                        r_state     <= c_st_ready;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        r_irq_done  <= 1'b1;
                    end else if (r_wdog == c_wd_last) begin
                        r_state       <= c_st_err;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                c_st_err: begin
                    r_state <= c_st_err;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign state          = r_state;
    assign weights_loaded = r_weights_loaded;
    assign frame_cnt      = r_frame_cnt;
    assign irq_done       = r_irq_done;
    assign err_order      = r_err_order;
    assign err_timeout    = r_err_timeout;

endmodule
`default_nettype wire
